// File: rtl/calc_pkg.sv
// Shared definitions for the calculator arithmetic unit: divider FSM states,
// default operand width and the divider step-counter width.
package calc_pkg;

    localparam int CALC_N     = 8;
    localparam int CALC_CNT_W = $clog2(CALC_N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } div_state_e;

    // Counter must hold the value n itself, not just n-1.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: trial-subtract the divisor magnitude from
// the shifted partial remainder and keep the result only if it is non-negative.
module div_step
    import calc_pkg::*;
#(
    parameter int N = CALC_N
) (
    input  logic [N:0]   shifted_rem,
    input  logic [N-1:0] divisor_mag,
    output logic [N-1:0] next_rem,
    output logic         q_bit
);

    logic [N:0] trial;

    assign trial    = shifted_rem - {1'b0, divisor_mag};
    assign q_bit    = ~trial[N];
    // The kept remainder is always below the divisor, so N bits suffice.
    assign next_rem = q_bit ? trial[N-1:0] : shifted_rem[N-1:0];

endmodule

// File: rtl/seq_divider.sv
// Sequential signed restoring divider with start/busy/done handshake.
// Build option: define DIV_SAT_EN to saturate the quotient on -2^(N-1) / -1.
module seq_divider
    import calc_pkg::*;
#(
    parameter int N = CALC_N
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] Dividend,
    input  logic [N-1:0] Divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] Quotient,
    output logic [N-1:0] Remainder,
    output logic         DivZero,
    output logic         OVR
);

    localparam int CW = cnt_width(N);

    div_state_e   state;
    logic         sign_a;
    logic         sign_b;
    logic [N-1:0] mag_a;     // dividend magnitude, shifts out as quotient bits shift in
    logic [N-1:0] mag_b;
    logic [N-1:0] rem;
    logic [CW-1:0] cnt;
    logic         dz_pend;

    logic [N-1:0] step_rem;
    logic         step_q;
    logic [N-1:0] fix_q;
    logic [N-1:0] fix_r;
    logic         fix_ovr;
    logic [N-1:0] wrap_q;

    function automatic logic [N-1:0] abs_mag(input logic [N-1:0] v);
        return v[N-1] ? (~v + N'(1)) : v;
    endfunction

    div_step #(.N(N)) u_step (
        .shifted_rem ({rem, mag_a[N-1]}),
        .divisor_mag (mag_b),
        .next_rem    (step_rem),
        .q_bit       (step_q)
    );

    // Overflow is the only way a same-sign quotient magnitude reaches 2^(N-1).
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        fix_q   = '0;
        fix_r   = '0;
        fix_ovr = 1'b0;
        wrap_q  = (sign_a ^ sign_b) ? -mag_a : mag_a;
        if (dz_pend) begin
            fix_r = sign_a ? -mag_a : mag_a;
        end else begin
            fix_ovr = (sign_a == sign_b) && mag_a[N-1];
`ifdef DIV_SAT_EN
            fix_q   = fix_ovr ? {1'b0, {(N-1){1'b1}}} : wrap_q;
`else
            fix_q   = wrap_q;
`endif
            fix_r   = sign_a ? -rem : rem;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            Quotient  <= '0;
            Remainder <= '0;
            DivZero   <= 1'b0;
            OVR       <= 1'b0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            mag_a     <= '0;
            mag_b     <= '0;
            rem       <= '0;
            cnt       <= '0;
            dz_pend   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sign_a <= Dividend[N-1];
                        sign_b <= Divisor[N-1];
                        mag_a  <= abs_mag(Dividend);
                        mag_b  <= abs_mag(Divisor);
                        rem    <= '0;
                        busy   <= 1'b1;
                        // A zero divisor waits one FIX cycle so done lands 2 clocks after accept.
                        if (Divisor == '0) begin
                            dz_pend <= 1'b1;
                            cnt     <= CW'(1);
                            state   <= FIX;
                        end else begin
                            dz_pend <= 1'b0;
                            cnt     <= CW'(N);
                            state   <= ITER;
                        end
                    end
                end
                ITER: begin
                    rem   <= step_rem;
                    mag_a <= {mag_a[N-2:0], step_q};
                    cnt   <= cnt - CW'(1);
                    if (cnt == CW'(1)) state <= FIX;
                end
                FIX: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        Quotient  <= fix_q;
                        Remainder <= fix_r;
                        DivZero   <= dz_pend;
                        OVR       <= fix_ovr;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: arithmetic reference model plus
// directed vectors with hand-computed results, latency and handshake checks.
module tb_seq_divider;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [N-1:0] Dividend;
    logic [N-1:0] Divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] Quotient;
    logic [N-1:0] Remainder;
    logic         DivZero;
    logic         OVR;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dz;
        logic         ovr;
    } res_t;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dz;
        logic         ovr;
        int           lat;
    } vec_t;

    res_t exp_fifo[$];
    res_t cur;
    bit   cur_valid = 1'b0;

    seq_divider #(.N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .busy      (busy),
        .done      (done),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .DivZero   (DivZero),
        .OVR       (OVR)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer division, truncating toward zero.
    function automatic res_t model(input logic [N-1:0] a, input logic [N-1:0] b);
        res_t res;
        int ia;
        int ib;
        ia = $signed(a);
        ib = $signed(b);
        res = '{q: '0, r: '0, dz: 1'b0, ovr: 1'b0};
        if (ib == 0) begin
            res.r  = a;
            res.dz = 1'b1;
        end else if (ia == -(1 << (N-1)) && ib == -1) begin
            res.ovr = 1'b1;
`ifdef DIV_SAT_EN
            res.q = N'((1 << (N-1)) - 1);
`else
            res.q = N'(-(1 << (N-1)));
`endif
        end else begin
            res.q = N'(ia / ib);
            res.r = N'(ia % ib);
        end
        return res;
    endfunction

    // Compare process: results must match the model from done onward and stay held.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                cur_valid = 1'b0;
                exp_fifo.delete();
            end else begin
                if (done) begin
                    if (exp_fifo.size() == 0) begin
                        check("done_without_request", 32'(done), 32'd0);
                    end else begin
                        cur = exp_fifo.pop_front();
                        cur_valid = 1'b1;
                    end
                end
                if (cur_valid) begin
                    check("model_q",   32'(Quotient),  32'(cur.q));
                    check("model_r",   32'(Remainder), 32'(cur.r));
                    check("model_dz",  32'(DivZero),   32'(cur.dz));
                    check("model_ovr", 32'(OVR),       32'(cur.ovr));
                end
            end
        end
    end

    // Drives start for exactly the accepting edge; returns at accept edge + 1.
    task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b);
        @(negedge clk);
        Dividend = a;
        Divisor  = b;
        start    = 1'b1;
        exp_fifo.push_back(model(a, b));
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_accept", 32'(busy), 32'd1);
    endtask

    // Counts edges from now until done is seen, bounded.
    task automatic wait_done(input string name, input int exp_edges);
        int  n = 0;
        bit  got = 1'b0;
        while (!got && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (done) got = 1'b1;
        end
        check({name, "_latency"}, 32'(n), 32'(exp_edges));
    endtask

    task automatic check_lit(input string name, input logic [N-1:0] q, input logic [N-1:0] r,
                             input logic dz, input logic ovr);
        check({name, "_q"},   32'(Quotient),  32'(q));
        check({name, "_r"},   32'(Remainder), 32'(r));
        check({name, "_dz"},  32'(DivZero),   32'(dz));
        check({name, "_ovr"}, 32'(OVR),       32'(ovr));
    endtask

    localparam logic [N-1:0] OVF_Q =
`ifdef DIV_SAT_EN
        8'h7F;
`else
        8'h80;
`endif

    vec_t vecs[$] = '{
        '{a: 8'd100, b: 8'd7,   q: 8'h0E, r: 8'h02, dz: 1'b0, ovr: 1'b0, lat: 9},
        '{a: 8'h9C,  b: 8'd7,   q: 8'hF2, r: 8'hFE, dz: 1'b0, ovr: 1'b0, lat: 9},
        '{a: 8'd100, b: 8'hF9,  q: 8'hF2, r: 8'h02, dz: 1'b0, ovr: 1'b0, lat: 9},
        '{a: 8'h9C,  b: 8'hF9,  q: 8'h0E, r: 8'hFE, dz: 1'b0, ovr: 1'b0, lat: 9},
        '{a: 8'h80,  b: 8'hFF,  q: OVF_Q, r: 8'h00, dz: 1'b0, ovr: 1'b1, lat: 9},
        '{a: 8'd5,   b: 8'd0,   q: 8'h00, r: 8'h05, dz: 1'b1, ovr: 1'b0, lat: 2},
        '{a: 8'd0,   b: 8'd5,   q: 8'h00, r: 8'h00, dz: 1'b0, ovr: 1'b0, lat: 9},
        '{a: 8'd3,   b: 8'd7,   q: 8'h00, r: 8'h03, dz: 1'b0, ovr: 1'b0, lat: 9},
        '{a: 8'hFD,  b: 8'd7,   q: 8'h00, r: 8'hFD, dz: 1'b0, ovr: 1'b0, lat: 9},
        '{a: 8'h80,  b: 8'd1,   q: 8'h80, r: 8'h00, dz: 1'b0, ovr: 1'b0, lat: 9},
        '{a: 8'd127, b: 8'hFF,  q: 8'h81, r: 8'h00, dz: 1'b0, ovr: 1'b0, lat: 9},
        '{a: 8'h80,  b: 8'd0,   q: 8'h00, r: 8'h80, dz: 1'b1, ovr: 1'b0, lat: 2}
    };

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        Dividend = '0;
        Divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check_lit("reset", 8'h00, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            start_op(vecs[i].a, vecs[i].b);
            wait_done($sformatf("vec%0d", i), vecs[i].lat);
            check_lit($sformatf("vec%0d", i), vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].ovr);
            check("busy_in_done_cycle", 32'(busy), 32'd0);
            @(posedge clk);
            #1;
            check("done_one_cycle", 32'(done), 32'd0);
        end

        // start during busy must be ignored
        start_op(8'd50, 8'd3);
        @(negedge clk);
        Dividend = 8'd9;
        Divisor  = 8'd2;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        wait_done("busy_start", 8);
        check_lit("busy_start", 8'd16, 8'd2, 1'b0, 1'b0);

        // start in the done cycle is accepted
        Dividend = 8'd9;
        Divisor  = 8'd2;
        start    = 1'b1;
        exp_fifo.push_back(model(8'd9, 8'd2));
        @(posedge clk);
        #1;
        start = 1'b0;
        check("chain_busy", 32'(busy), 32'd1);
        check("chain_done_low", 32'(done), 32'd0);
        check_lit("chain_held", 8'd16, 8'd2, 1'b0, 1'b0);
        wait_done("chain", 9);
        check_lit("chain", 8'd4, 8'd1, 1'b0, 1'b0);

        // abort with reset on the 4th ITER cycle
        start_op(8'd100, 8'd7);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check_lit("abort", 8'h00, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            check("no_done_after_abort", 32'(done), 32'd0);
        end
        start_op(8'd20, 8'd4);
        wait_done("after_abort", 9);
        check_lit("after_abort", 8'd5, 8'd0, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
